dequantify_reader: RTL and testbench

- Consumer end of the quantized-activation FIFO. The quantizer writes 128-bit words of sixteen signed int8 lanes into that FIFO.
- This block reads one frame of words from the FIFO, unpacks each word into 16 lanes and dequantizes every lane as q*max_abs/127.
- It presents 16 signed 32-bit values per beat to the next conv layer through a valid/ready stream with backpressure.

---
 rtl/dequant_pkg.sv | 37 +++
 rtl/dequantify_reader_if.sv | 31 +++
 rtl/dequant_lane.sv | 42 ++++
 rtl/dequantify_reader.sv | 144 ++++++++++++++
 tb/tb_dequantify_reader.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dequant_pkg.sv
// dequant_pkg: shared constants, the controller state type and the output
// saturation helper for the dequantify_reader slice.
//   LANES    int8 lanes per FIFO word
//   QW       quantized lane width
//   OW       dequantized lane width
//   PROD_W   signed product width (QW + OW)
//   DIVISOR  dequantization divisor (max int8 magnitude)
package dequant_pkg;

   localparam int LANES  = 16;
   localparam int QW     = 8;
   localparam int OW     = 32;
   localparam int PROD_W = 40;

   localparam logic signed [PROD_W-1:0] DIVISOR = 40'sd127;
   localparam logic signed [PROD_W-1:0] OUT_MAX = 40'sd2147483647;
   localparam logic signed [PROD_W-1:0] OUT_MIN = -40'sd2147483648;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // Clamp a wide signed quotient into the OW-bit output range.
   function automatic logic [OW-1:0] sat_ow(input logic signed [PROD_W-1:0] v);
      logic [OW-1:0] r;
      if (v > OUT_MAX)
         r = OUT_MAX[OW-1:0];
      else if (v < OUT_MIN)
         r = OUT_MIN[OW-1:0];
      else
         r = v[OW-1:0];
      return r;
   endfunction

endpackage

// File: rtl/dequantify_reader_if.sv
// dequantify_reader_if: quantized-FIFO read port plus dequantized output stream.
//   rfifo_empty  FIFO empty flag                  (FIFO -> reader)
//   rfifo_en     FIFO read strobe                 (reader -> FIFO)
//   rfifo_data   read data, valid cycle after en  (FIFO -> reader)
//   dout_valid   output beat valid                (reader -> sink)
//   dout_ready   sink accepts                     (sink -> reader)
//   dout_data    LANES x OW dequantized lanes     (reader -> sink)
//   dout_last    final beat of the frame          (reader -> sink)
// master = the reader, slave = the FIFO/sink side.
interface dequantify_reader_if;
   import dequant_pkg::*;

   logic                  rfifo_empty;
   logic                  rfifo_en;
   logic [LANES*QW-1:0]   rfifo_data;
   logic                  dout_valid;
   logic                  dout_ready;
   logic [LANES*OW-1:0]   dout_data;
   logic                  dout_last;

   modport master (
      input  rfifo_empty, rfifo_data, dout_ready,
      output rfifo_en, dout_valid, dout_data, dout_last
   );

   modport slave (
      output rfifo_empty, rfifo_data, dout_ready,
      input  rfifo_en, dout_valid, dout_data, dout_last
   );

endinterface

// File: rtl/dequant_lane.sv
// dequant_lane: one lane of q*scale/127.
//   clk, rst  clock, async active-high reset
//   en        lane data valid this cycle (capture the product)
//   q         signed int8 lane value
//   scale     latched signed scale (already forced to 0 when non-positive)
//   y         saturated quotient, truncated toward zero
// The product is registered here; the quotient is combinational from that
// register and gets captured by the output buffer in the parent, which makes
// it the second registered stage.
module dequant_lane
   import dequant_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [QW-1:0]        q,
   input  logic signed [OW-1:0] scale,
   output logic [OW-1:0]        y
);

   logic signed [PROD_W-1:0] q_ext;
   logic signed [PROD_W-1:0] s_ext;
   logic signed [PROD_W-1:0] prod_q;
   logic signed [PROD_W-1:0] quo;

   assign q_ext = {{(PROD_W-QW){q[QW-1]}}, q};
   assign s_ext = {{(PROD_W-OW){scale[OW-1]}}, scale};

   // |q| <= 128 and |scale| < 2^31 keep the exact product inside PROD_W bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         prod_q <= '0;
      else if (en)
         prod_q <= q_ext * s_ext;
   end

   // Signed division truncates toward zero; only q=-128 at large scales
   // can leave the output range.
   assign quo = prod_q / DIVISOR;
   assign y   = sat_ow(quo);

endmodule

// File: rtl/dequantify_reader.sv
// dequantify_reader: reads one frame of quantized words from the FIFO,
// dequantizes each int8 lane as q*max_abs/127 and streams the results out.
//   clk, rst    clock, async active-high reset
//   start       one-cycle frame start (ignored unless idle)
//   max_abs     signed scale, sampled on an accepted start
//   busy        frame in progress
//   frame_done  one-cycle pulse after the last beat is accepted
//   io          FIFO read port + output stream (master side)
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing FIFO reads until FRAME_WORDS have been issued
// DRAIN | all reads issued, emptying pipeline and buffer until last beat
module dequantify_reader
   import dequant_pkg::*;
#(
   parameter int FRAME_WORDS = 64,
   parameter int BUF_DEPTH   = 4
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [OW-1:0]        max_abs,
   output logic                 busy,
   output logic                 frame_done,
   dequantify_reader_if.master  io
);

   localparam int IW = $clog2(FRAME_WORDS + 1);
   localparam int PW = $clog2(BUF_DEPTH);
   localparam int CW = $clog2(BUF_DEPTH + 1);
   localparam int EW = LANES * OW;

   state_t state, next_state;

   logic signed [OW-1:0] scale_q;
   logic [IW-1:0]        issued;
   logic                 v1, v2, l1, l2;
   logic [CW-1:0]        occ;
   logic [CW-1:0]        credit;
   logic [PW-1:0]        wr_ptr, rd_ptr;
   logic [EW:0]          buf_mem [BUF_DEPTH];
   logic [EW:0]          head;
   logic [EW-1:0]        lane_y;
   logic                 start_ok, rd_en, push, pop, last_hs;

   // ------------------------------------------------------------------ FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = RUN;
         RUN:     if (issued == IW'(FRAME_WORDS)) next_state = DRAIN;
         DRAIN:   if (last_hs) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Every word in the 2-stage datapath already owns a buffer slot, so a
   // read is only issued while (inflight + occupancy) leaves a free slot.
   always_comb begin
      busy  = (state != IDLE);
      rd_en = (state == RUN) && !io.rfifo_empty &&
              (issued < IW'(FRAME_WORDS)) && (credit < CW'(BUF_DEPTH));
   end

   // ------------------------------------------------------------- datapath
   assign start_ok = (state == IDLE) && start;
   assign credit   = occ + CW'(v1) + CW'(v2);
   assign push     = v2;
   assign pop      = io.dout_valid && io.dout_ready;
   assign last_hs  = pop && io.dout_last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scale_q    <= '0;
         issued     <= '0;
         v1         <= 1'b0;
         l1         <= 1'b0;
         v2         <= 1'b0;
         l2         <= 1'b0;
         occ        <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         frame_done <= 1'b0;
      end else begin
         // A non-positive scale is latched as 0 so every product is 0 while
         // the frame still runs through the normal handshake.
         if (start_ok) begin
            scale_q <= ($signed(max_abs) > 0) ? $signed(max_abs) : '0;
            issued  <= '0;
         end else if (rd_en) begin
            issued  <= issued + IW'(1);
         end

         v1 <= rd_en;
         l1 <= rd_en && (issued == IW'(FRAME_WORDS - 1));
         v2 <= v1;
         l2 <= l1;

         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);

         case ({push, pop})
            2'b10:   occ <= occ + CW'(1);
            2'b01:   occ <= occ - CW'(1);
            default: occ <= occ;
         endcase

         frame_done <= last_hs;
      end
   end

   // Buffer storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push)
         buf_mem[wr_ptr] <= {l2, lane_y};
   end

   assign head          = buf_mem[rd_ptr];
   assign io.rfifo_en   = rd_en;
   assign io.dout_valid = (occ != '0);
   assign io.dout_data  = io.dout_valid ? head[EW-1:0] : '0;
   assign io.dout_last  = io.dout_valid & head[EW];

   // ---------------------------------------------------------------- lanes
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      dequant_lane u_lane (
         .clk   (clk),
         .rst   (rst),
         .en    (v1),
         .q     (io.rfifo_data[i*QW +: QW]),
         .scale (scale_q),
         .y     (lane_y[i*OW +: OW])
      );
   end

endmodule

// File: tb/tb_dequantify_reader.sv
module tb_dequantify_reader;
   import dequant_pkg::*;

   localparam int FW = 64;
   localparam int BD = 4;
   localparam int DW = LANES * OW;
   localparam int NV = 5;

   typedef struct {
      logic [LANES*QW-1:0] word;
      logic [OW-1:0]       scale;
      logic [DW-1:0]       exp;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start, start1;
   logic [OW-1:0] max_abs, max_abs1;
   logic          busy, frame_done, busy1, frame_done1;
   int            n_cmp = 0;
   int            n_err = 0;

   logic [LANES*QW-1:0] fifo_q [$];
   vec_t                tv [NV];

   dequantify_reader_if io();
   dequantify_reader_if io1();

   dequantify_reader #(.FRAME_WORDS(FW), .BUF_DEPTH(BD)) u_dut (
      .clk(clk), .rst(rst), .start(start), .max_abs(max_abs),
      .busy(busy), .frame_done(frame_done), .io(io)
   );

   dequantify_reader #(.FRAME_WORDS(1), .BUF_DEPTH(BD)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .max_abs(max_abs1),
      .busy(busy1), .frame_done(frame_done1), .io(io1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [DW+1:0] got, input logic [DW+1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h want=%0h", name, got, exp);
      end
   endtask

   // Reference: q*scale/127 with plain integer arithmetic.
   function automatic logic [DW-1:0] ref_word(input logic [LANES*QW-1:0] w, input logic [OW-1:0] s);
      logic [DW-1:0] r;
      longint sl, q, d;
      logic [63:0] dv;
      sl = longint'($signed(s));
      for (int i = 0; i < LANES; i++) begin
         q = longint'($signed(w[i*QW +: QW]));
         if (sl <= 0) d = 0;
         else begin
            d = (q * sl) / 127;
            if (d > 64'sd2147483647) d = 64'sd2147483647;
            if (d < -64'sd2147483648) d = -64'sd2147483648;
         end
         dv = d;
         r[i*OW +: OW] = dv[OW-1:0];
      end
      return r;
   endfunction

   function automatic logic [LANES*QW-1:0] pack_q(input int a[LANES]);
      logic [LANES*QW-1:0] r;
      logic [31:0] t;
      for (int i = 0; i < LANES; i++) begin t = a[i]; r[i*QW +: QW] = t[QW-1:0]; end
      return r;
   endfunction

   function automatic logic [DW-1:0] pack_o(input int a[LANES]);
      logic [DW-1:0] r;
      for (int i = 0; i < LANES; i++) r[i*OW +: OW] = a[i];
      return r;
   endfunction

   function automatic logic [LANES*QW-1:0] rand_word();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic fill_frame();
      repeat (FW) fifo_q.push_back(rand_word());
   endtask

   task automatic idle_check(input int n);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (busy || io.rfifo_en || io.dout_valid || frame_done) bad = 1'b1;
      end
      chk("idle_quiet", bad, 0);
   endtask

   // mode 0: ready=1, no stalls; 1: ready low for 20 cycles;
   // 2: random ready/empty plus a stray start mid-frame.
   task automatic run_frame(input logic [OW-1:0] s, input int mode, input int rst_after,
                            output logic [DW-1:0] first_beat, output int latency);
      logic [DW-1:0] exp_d [FW];
      logic [DW-1:0] prev_data;
      logic prev_last, hold_prev, prev_last_hs, en_s, hs, done, did_rst, stall;
      int beats, reads, run_len, max_run, first_en, first_val, max_ahead;
      for (int k = 0; k < FW; k++) exp_d[k] = ref_word(fifo_q[k], s);
      beats = 0; reads = 0; run_len = 0; max_run = 0; first_en = -1; first_val = -1;
      max_ahead = 0; hold_prev = 0; prev_last_hs = 0; done = 0; did_rst = 0;
      first_beat = '0; prev_data = '0; prev_last = 0;
      @(posedge clk); #1;
      start = 1'b1; max_abs = s; io.dout_ready = 1'b1;
      io.rfifo_empty = (fifo_q.size() == 0);
      for (int cyc = 0; cyc < 3000 && !done && !did_rst; cyc++) begin
         @(negedge clk);
         en_s = io.rfifo_en;
         if (en_s) begin
            chk("rd_while_empty", {io.rfifo_empty, fifo_q.size() == 0}, 0);
            reads++; run_len++;
            if (run_len > max_run) max_run = run_len;
            if (first_en < 0) first_en = cyc;
            if (reads - beats > max_ahead) max_ahead = reads - beats;
         end else run_len = 0;
         if (io.dout_valid && first_val < 0) first_val = cyc;
         if (hold_prev)
            chk("hold_stable", {io.dout_valid, io.dout_last, io.dout_data}, {1'b1, prev_last, prev_data});
         hs = io.dout_valid & io.dout_ready;
         if (hs) begin
            if (beats < FW)
               chk($sformatf("beat%0d", beats), {io.dout_last, io.dout_data}, {beats == FW-1, exp_d[beats]});
            else
               chk("beat_overrun", beats, FW-1);
            if (beats == 0) first_beat = io.dout_data;
            beats++;
         end
         if (frame_done) begin
            chk("busy_at_done", busy, 0);
            chk("done_after_last", prev_last_hs, 1);
            chk("beats_at_done", beats, FW);
            done = 1'b1;
         end
         prev_last_hs = hs & io.dout_last;
         hold_prev    = io.dout_valid & ~io.dout_ready;
         prev_data    = io.dout_data;
         prev_last    = io.dout_last;
         @(posedge clk); #1;
         if (en_s && fifo_q.size() > 0) io.rfifo_data = fifo_q.pop_front();
         start = 1'b0;
         stall = 1'b0;
         if (rst_after > 0 && beats >= rst_after) begin
            rst = 1'b1;
            did_rst = 1'b1;
         end
         case (mode)
            1: io.dout_ready = !(cyc >= 20 && cyc < 40);
            2: begin
               io.dout_ready = ($urandom_range(0, 3) != 0);
               stall = ($urandom_range(0, 3) == 0);
               if (cyc == 12) begin start = 1'b1; max_abs = ~s; end
            end
            default: io.dout_ready = 1'b1;
         endcase
         io.rfifo_empty = stall || (fifo_q.size() == 0);
      end
      latency = first_val - first_en;
      if (did_rst) begin
         @(negedge clk);
         chk("rst_ctrl", {busy, io.dout_valid, io.rfifo_en, frame_done, io.dout_last}, 0);
         chk("rst_data", io.dout_data, 0);
         @(posedge clk); #1;
         rst = 1'b0;
      end else begin
         chk("frame_finished", done, 1);
         chk("ahead_le_depth", max_ahead <= BD, 1);
         if (mode == 0) chk("en_run_len", max_run, FW);
      end
   endtask

   initial begin
      int la[LANES];
      int le[LANES];
      logic [DW-1:0] fb;
      int lat, ens, vcyc, dcyc;

      rst = 1'b1; start = 1'b0; start1 = 1'b0; max_abs = '0; max_abs1 = '0;
      io.dout_ready = 1'b0; io.rfifo_empty = 1'b1; io.rfifo_data = '0;
      io1.dout_ready = 1'b1; io1.rfifo_empty = 1'b0; io1.rfifo_data = '0;

      // v0: {127,-1,-128,0, rest 1} x 1000
      for (int i = 0; i < LANES; i++) begin la[i] = 1; le[i] = 7; end
      la[0] = 127; la[1] = -1; la[2] = -128; la[3] = 0;
      le[0] = 1000; le[1] = -7; le[2] = -1007; le[3] = 0;
      tv[0].word = pack_q(la); tv[0].scale = 32'd1000; tv[0].exp = pack_o(le);
      // v1: all 64 x 254 -> 128
      for (int i = 0; i < LANES; i++) begin la[i] = 64; le[i] = 128; end
      tv[1].word = pack_q(la); tv[1].scale = 32'd254; tv[1].exp = pack_o(le);
      // v2/v3: zero and negative scale -> all zero
      tv[2].word = tv[0].word; tv[2].scale = 32'd0;          tv[2].exp = '0;
      tv[3].word = tv[0].word; tv[3].scale = 32'hFFFF_FFFB;  tv[3].exp = '0;
      // v4: saturation at full-range scale
      for (int i = 0; i < LANES; i++) begin la[i] = 0; le[i] = 0; end
      la[0] = 127; la[1] = -128; la[2] = 1; la[3] = -1;
      le[0] = 2147483647; le[1] = int'(32'h8000_0000); le[2] = 16909320; le[3] = -16909320;
      tv[4].word = pack_q(la); tv[4].scale = 32'h7FFF_FFFF; tv[4].exp = pack_o(le);

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_ctrl", {busy, io.dout_valid, io.rfifo_en, frame_done, io.dout_last}, 0);
      chk("reset_data", io.dout_data, 0);
      chk("reset_ctrl1", {busy1, io1.dout_valid, io1.rfifo_en, frame_done1}, 0);

      for (int v = 0; v < NV; v++) begin
         fifo_q.push_back(tv[v].word);
         repeat (FW-1) fifo_q.push_back(rand_word());
         run_frame(tv[v].scale, 0, 0, fb, lat);
         chk($sformatf("table_v%0d", v), fb, tv[v].exp);
         chk($sformatf("latency_v%0d", v), lat, 3);
         idle_check(3);
      end

      fill_frame();
      run_frame($urandom_range(1, 100000), 1, 0, fb, lat);
      idle_check(3);

      for (int r = 0; r < 3; r++) begin
         fill_frame();
         run_frame((r == 1) ? $urandom : $urandom_range(1, 1 << 24), 2, 0, fb, lat);
         idle_check(10);
      end

      fill_frame();
      run_frame($urandom_range(1, 5000), 0, 10, fb, lat);
      fill_frame();
      run_frame($urandom_range(1, 5000), 0, 0, fb, lat);
      idle_check(3);

      // single-word frame on the second instance
      @(posedge clk); #1;
      start1 = 1'b1; max_abs1 = 32'd1000; io1.rfifo_data = tv[0].word;
      ens = 0; vcyc = -1; dcyc = -1;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (io1.rfifo_en) ens++;
         if (io1.dout_valid && vcyc < 0) begin
            vcyc = c;
            chk("fw1_last", io1.dout_last, 1);
            chk("fw1_data", io1.dout_data, tv[0].exp);
         end
         if (frame_done1 && dcyc < 0) dcyc = c;
         @(posedge clk); #1;
         start1 = 1'b0;
      end
      chk("fw1_reads", ens, 1);
      chk("fw1_valid_seen", vcyc >= 0, 1);
      chk("fw1_done_lat", dcyc - vcyc, 1);
      chk("fw1_idle", busy1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
